// File: rtl/f_pc_ctrl.sv
// F-stage program-counter sequencer: picks the next fetch PC and buffers stalled redirects.
// Optional macro PC_RANGE_CHECK_EN adds a [TEXT_LO, TEXT_HI] window to the fetch address error.
//
// state | meaning
// RUN   | no redirect buffered; pc follows sequential/redirect sources
// PEND  | redirect captured under stall, held in pend_target until stall drops
module f_pc_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
   parameter logic [31:0] TEXT_HI    = 32'h0000_6FFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   output logic [31:0] pc,
   output logic        exc_adel,
   output logic        pend,
   output logic        redirect
);

   typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

`ifdef PC_RANGE_CHECK_EN
   localparam logic RANGE_EN = 1'b1;
`else
   localparam logic RANGE_EN = 1'b0;
`endif

   state_t      state, state_nxt;
   logic [31:0] pc_nxt;
   logic [31:0] pend_target, pend_target_nxt;
   logic        redirect_nxt;
   logic        misalign, out_of_range;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         pc          <= RESET_PC;
         pend_target <= '0;
         redirect    <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         pend_target <= pend_target_nxt;
         redirect    <= redirect_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      pend_target_nxt = pend_target;
      redirect_nxt    = 1'b0;
      if (exc_req) begin
         pc_nxt          = HANDLER_PC;
         state_nxt       = RUN;
         pend_target_nxt = '0;
         redirect_nxt    = 1'b1;
      end else if (stall) begin
         // A newer request from the held D slot overwrites any earlier buffered one.
         if (eret_req) begin
            pend_target_nxt = epc;
            state_nxt       = PEND;
         end else if (br_valid) begin
            pend_target_nxt = br_target;
            state_nxt       = PEND;
         end
      end else if (state == PEND) begin
         // Same-cycle eret/branch belong to the instruction already buffered; ignore them.
         pc_nxt       = pend_target;
         state_nxt    = RUN;
         redirect_nxt = 1'b1;
      end else if (eret_req) begin
         pc_nxt       = epc;
         redirect_nxt = 1'b1;
      end else if (br_valid) begin
         pc_nxt       = br_target;
         redirect_nxt = 1'b1;
      end else begin
         pc_nxt = pc + 32'd4;
      end
   end

   always_comb begin
      pend         = (state == PEND);
      misalign     = (pc[1:0] != 2'b00);
      out_of_range = (pc < TEXT_LO) || (pc > TEXT_HI);
      // The slot under an eret is squashed, so it can never raise AdEL.
      exc_adel     = (misalign || (RANGE_EN && out_of_range)) && !eret_req;
   end

endmodule

// File: tb/tb_f_pc_ctrl.sv
// Directed self-checking bench for f_pc_ctrl; expectations follow PC_RANGE_CHECK_EN if defined.
module tb_f_pc_ctrl;

   logic        clk = 1'b0;
   logic        reset, stall, exc_req, eret_req, br_valid;
   logic [31:0] epc, br_target;
   logic [31:0] pc;
   logic        exc_adel, pend, redirect;

   int checks = 0;
   int errors = 0;

`ifdef PC_RANGE_CHECK_EN
   localparam logic RANGE_EN = 1'b1;
`else
   localparam logic RANGE_EN = 1'b0;
`endif

   f_pc_ctrl dut (
      .clk(clk), .reset(reset), .stall(stall), .exc_req(exc_req),
      .eret_req(eret_req), .epc(epc), .br_valid(br_valid), .br_target(br_target),
      .pc(pc), .exc_adel(exc_adel), .pend(pend), .redirect(redirect)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_pend,
                          input logic e_redir, input logic e_adel);
      chk({tag, "_pc"}, pc, e_pc);
      chk({tag, "_pend"}, {31'd0, pend}, {31'd0, e_pend});
      chk({tag, "_redirect"}, {31'd0, redirect}, {31'd0, e_redir});
      chk({tag, "_adel"}, {31'd0, exc_adel}, {31'd0, e_adel});
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; exc_req = 1'b1; eret_req = 1'b0; br_valid = 1'b0;
      epc = '0; br_target = '0;
      step();
      exc_req = 1'b0;
      step();
      reset = 1'b0;
      chk_all("reset", 32'h3000, 1'b0, 1'b0, 1'b0);

      step(); chk_all("seq1", 32'h3004, 1'b0, 1'b0, 1'b0);
      step(); chk_all("seq2", 32'h3008, 1'b0, 1'b0, 1'b0);
      step(); chk_all("seq3", 32'h300C, 1'b0, 1'b0, 1'b0);
      step(); chk_all("seq4", 32'h3010, 1'b0, 1'b0, 1'b0);

      br_valid = 1'b1; br_target = 32'h3400;
      step(); chk_all("br", 32'h3400, 1'b0, 1'b1, 1'b0);
      br_valid = 1'b0;
      step(); chk_all("br_seq", 32'h3404, 1'b0, 1'b0, 1'b0);

      stall = 1'b1; br_valid = 1'b1; br_target = 32'h3800;
      step(); chk_all("stall1", 32'h3404, 1'b1, 1'b0, 1'b0);
      br_valid = 1'b0;
      step(); chk_all("stall2", 32'h3404, 1'b1, 1'b0, 1'b0);
      step(); chk_all("stall3", 32'h3404, 1'b1, 1'b0, 1'b0);
      stall = 1'b0; br_valid = 1'b1; br_target = 32'h3900;
      step(); chk_all("pend_apply", 32'h3800, 1'b0, 1'b1, 1'b0);
      br_valid = 1'b0;
      step(); chk_all("pend_seq", 32'h3804, 1'b0, 1'b0, 1'b0);

      stall = 1'b1; br_valid = 1'b1; br_target = 32'h3A00;
      step(); chk_all("exc_pend", 32'h3804, 1'b1, 1'b0, 1'b0);
      br_valid = 1'b0; exc_req = 1'b1;
      step(); chk_all("exc", 32'h4180, 1'b0, 1'b1, 1'b0);
      exc_req = 1'b0;
      step(); chk_all("exc_hold", 32'h4180, 1'b0, 1'b0, 1'b0);
      stall = 1'b0;
      step(); chk_all("exc_seq", 32'h4184, 1'b0, 1'b0, 1'b0);

      eret_req = 1'b1; epc = 32'h3002;
      step(); chk_all("eret_mis_gated", 32'h3002, 1'b0, 1'b1, 1'b0);
      eret_req = 1'b0;
      #1 chk("eret_mis_adel", {31'd0, exc_adel}, 32'd1);
      eret_req = 1'b1; epc = 32'h3008;
      #1 chk("eret_gate_adel", {31'd0, exc_adel}, 32'd0);
      step(); eret_req = 1'b0;
      chk_all("eret_aligned", 32'h3008, 1'b0, 1'b1, 1'b0);

      br_valid = 1'b1; br_target = 32'h7000;
      step(); chk_all("range_hi", 32'h7000, 1'b0, 1'b1, RANGE_EN);
      br_target = 32'h6FFC;
      step(); chk_all("range_edge", 32'h6FFC, 1'b0, 1'b1, 1'b0);
      br_target = 32'h2FFC;
      step(); chk_all("range_lo", 32'h2FFC, 1'b0, 1'b1, RANGE_EN);

      br_target = 32'h3200; eret_req = 1'b1; epc = 32'h3100;
      step(); chk("prio_eret_pc", pc, 32'h3100);
      eret_req = 1'b0; br_target = 32'hFFFF_FFFC;
      step(); chk_all("wrap_pre", 32'hFFFF_FFFC, 1'b0, 1'b1, RANGE_EN);
      br_valid = 1'b0;
      step(); chk_all("wrap", 32'h0000_0000, 1'b0, 1'b0, RANGE_EN);

      stall = 1'b1; br_valid = 1'b1; br_target = 32'h3500;
      step(); chk("rst_pend_pre", {31'd0, pend}, 32'd1);
      br_valid = 1'b0; reset = 1'b1;
      step(); chk_all("rst_pend", 32'h3000, 1'b0, 1'b0, 1'b0);
      reset = 1'b0; stall = 1'b0;
      step(); chk_all("rst_after", 32'h3004, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
